// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : rv_instr_encoder
// Brief   : Encodes symbolic RV32I requests (lw/sw/R/I/jal/beq/bne) and
//           streams the words into instruction memory via a small FIFO.
//           Optional build macro RV_ENC_STATS_EN adds write/reject counters.
// Revision: 1.0 - initial release
// ============================================================================
module rv_instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clr
`ifdef RV_ENC_STATS_EN
  ,
  output logic [15:0]       n_written,
  output logic [15:0]       n_rejected
`endif
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  localparam logic [2:0] c_kind_lw  = 3'd0;
  localparam logic [2:0] c_kind_sw  = 3'd1;
  localparam logic [2:0] c_kind_r   = 3'd2;
  localparam logic [2:0] c_kind_i   = 3'd3;
  localparam logic [2:0] c_kind_jal = 3'd4;
  localparam logic [2:0] c_kind_beq = 3'd5;
  localparam logic [2:0] c_kind_bne = 3'd6;

  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [2:0] c_alu_slt = 3'd2;
  localparam logic [2:0] c_alu_or  = 3'd3;
  localparam logic [2:0] c_alu_and = 3'd4;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  localparam logic [1:0] c_err_none  = 2'd0;
  localparam logic [1:0] c_err_kind  = 2'd1;
  localparam logic [1:0] c_err_range = 2'd2;
  localparam logic [1:0] c_err_align = 2'd3;

  localparam logic signed [20:0] c_i_min = -21'sd2048;
  localparam logic signed [20:0] c_i_max = 21'sd2047;
  localparam logic signed [20:0] c_b_min = -21'sd4096;
  localparam logic signed [20:0] c_b_max = 21'sd4094;
  localparam logic signed [20:0] c_j_max = 21'sd1048574;

  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  logic [31:0]         w_word;
  logic                w_bad;
  logic                w_oor;
  logic                w_mis;
  logic                w_i_oor;
  logic                w_b_oor;
  logic [1:0]          w_code;
  logic signed [20:0]  w_imm_s;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_reject;
  logic [c_cnt_w-1:0]  w_count_nxt;

  logic [31:0]         r_fifo [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_err;
  logic [1:0]          r_err_code;

  assign w_imm_s = $signed(in_imm);
  assign w_i_oor = (w_imm_s < c_i_min) || (w_imm_s > c_i_max);
  assign w_b_oor = (w_imm_s < c_b_min) || (w_imm_s > c_b_max);

  always_comb begin
    w_f3 = 3'b000;
    w_f7 = 7'b0000000;
    case (in_alu)
      c_alu_add: w_f3 = 3'b000;
      c_alu_sub: begin
        w_f3 = 3'b000;
        w_f7 = 7'b0100000;
      end
      c_alu_slt: w_f3 = 3'b010;
      c_alu_or:  w_f3 = 3'b110;
      c_alu_and: w_f3 = 3'b111;
      default:   w_f3 = 3'b000;
    endcase
  end

  // Unused fields stay zero; the J-range lower bound is the 21-bit minimum itself.
  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    w_oor  = 1'b0;
    w_mis  = 1'b0;
    case (in_kind)
      c_kind_lw: begin
        w_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, c_op_load};
        w_oor  = w_i_oor;
      end
      c_kind_sw: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], c_op_store};
        w_oor  = w_i_oor;
      end
      c_kind_r: begin
        w_word = {w_f7, in_rs2, in_rs1, w_f3, in_rd, c_op_r};
        w_bad  = (in_alu > c_alu_and);
      end
      c_kind_i: begin
        w_word = {in_imm[11:0], in_rs1, w_f3, in_rd, c_op_i};
        w_bad  = (in_alu > c_alu_and) || (in_alu == c_alu_sub);
        w_oor  = w_i_oor;
      end
      c_kind_jal: begin
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, c_op_jal};
        w_oor  = (w_imm_s > c_j_max);
        w_mis  = in_imm[0];
      end
      c_kind_beq, c_kind_bne: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                  (in_kind == c_kind_bne) ? 3'b001 : 3'b000,
                  in_imm[4:1], in_imm[11], c_op_branch};
        w_oor  = w_b_oor;
        w_mis  = in_imm[0];
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_code = c_err_none;
    if (w_bad)      w_code = c_err_kind;
    else if (w_oor) w_code = c_err_range;
    else if (w_mis) w_code = c_err_align;
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_push   = w_accept && (w_code == c_err_none);
  assign w_reject = w_accept && (w_code != c_err_none);
  assign w_pop    = r_mem_we && mem_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_word;
  end

  // Ready and write-valid are flops of the next occupancy, so mem_ready never reaches in_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
      r_mem_we   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != c_full);
      r_mem_we   <= (w_count_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= BASE_ADDR;
    end else if (addr_load) begin
      r_addr <= addr_value;
    end else if (w_pop) begin
      r_addr <= r_addr + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err      <= 1'b0;
      r_err_code <= c_err_none;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= c_err_none;
    end else if (w_reject && !r_err) begin
      r_err      <= 1'b1;
      r_err_code <= w_code;
    end
  end

`ifdef RV_ENC_STATS_EN
  logic [15:0] r_n_written;
  logic [15:0] r_n_rejected;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_written  <= '0;
      r_n_rejected <= '0;
    end else begin
      if (w_pop && (r_n_written != 16'hFFFF))     r_n_written  <= r_n_written + 16'd1;
      if (w_reject && (r_n_rejected != 16'hFFFF)) r_n_rejected <= r_n_rejected + 16'd1;
    end
  end

  assign n_written  = r_n_written;
  assign n_rejected = r_n_rejected;
`endif

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_mem_we ? r_fifo[r_rd_ptr] : 32'h0;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the main control decode: accepts symbolic instruction requests (kind, registers, immediate) and encodes them into RV32I words.
- Writes the encoded words sequentially into instruction memory through a registered write port.
- Used to build boot/test programs in hardware.
- Covers the instruction subset the datapath decodes: lw, sw, R-type, I-type ALU, jal, beq, bne.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- DEPTH, 2, encoded-word FIFO depth (power of 2, ≥2).
- BASE_ADDR, 0, address counter value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request can be accepted (FIFO not full).
- in_kind  input  3  0 lw, 1 sw, 2 R-type, 3 I-type ALU, 4 jal, 5 beq, 6 bne, 7 illegal.
- in_alu  input  3  0 add, 1 sub, 2 slt, 3 or, 4 and; used only by R/I kinds.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_imm  input  21  signed immediate / byte offset.
- addr_load  input  1  load the address counter.
- addr_value  input  ADDR_W  value loaded by addr_load.
- mem_we  output  1  write valid (FIFO non-empty).
- mem_ready  input  1  memory accepts the write.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  encoded instruction.
- err  output  1  sticky rejection flag.
- err_code  output  2  1 bad kind/alu, 2 imm out of range, 3 misaligned offset; 0 none.
- err_clr  input  1  clears err and err_code.

Behaviour:
- Reset values:
  - in_ready=1, mem_we=0, mem_wdata=0, mem_addr=BASE_ADDR.
  - err=0, err_code=0, FIFO empty.
- Accept: a request is accepted when in_valid && in_ready. It is encoded combinationally and range-checked the same cycle.
- Legal request: the word is enqueued and appears on mem_wdata with mem_we=1 at the next clock edge at the earliest (latency 1).
- Illegal request: it is still accepted (handshake completes) but not enqueued. err is set to 1 and err_code is loaded only if err was 0, so the first error wins.
- Encodings (funct3 / funct7):
  - lw: op 0000011, funct3 010.
  - sw: op 0100011, funct3 010.
  - R-type: op 0110011. add 000/0000000, sub 000/0100000, slt 010, or 110, and 111.
  - I-type: op 0010011, same funct3 as R-type.
  - jal: op 1101111.
  - beq: op 1100011, funct3 000.
  - bne: op 1100011, funct3 001.
- Field use: unused fields are encoded as 0 (e.g. rs2 for I-type, rd for sw/branches).
- Illegal cases:
  - in_kind=7.
  - in_alu>4.
  - sub with in_kind=3.
  - in_alu≠0 with R/I kind... no: in_alu is ignored for non-R/I kinds.
- Range checks (signed):
  - I/S: −2048..2047.
  - B: −4096..4094, and bit0 must be 0.
  - J: −1048576..1048574, and bit0 must be 0.
  - Out of range takes priority over misaligned.
- Memory handshake: a write completes when mem_we && mem_ready. On completion the FIFO pops and mem_addr += 4, wrapping modulo 2^ADDR_W. mem_addr/mem_wdata stay stable while mem_we=1 and mem_ready=0.
- FIFO full: in_ready=0. A same-cycle pop does NOT raise in_ready (registered ready, no combinational path from mem_ready).
- Simultaneous push and pop on a non-full FIFO: both occur, and the count is unchanged.
- addr_load:
  - Takes effect at the edge.
  - If a write completes the same cycle, that write uses the old address and the counter becomes addr_value (no +4).
- err_clr: has priority over a same-cycle new error, which is lost.
- Reset mid-operation: the FIFO is flushed, the counter returns to BASE_ADDR, and pending words are discarded.

Optional Feature:
- Macro: RV_ENC_STATS_EN.
- Enabled: adds outputs n_written[15:0] (completed memory writes) and n_rejected[15:0] (illegal requests). Both reset to 0 and saturate at 0xFFFF.
- Disabled: the ports and counters are absent, and the other behaviour is identical.

Test Plan:
- addi x1,x0,5 (kind 3, alu 0, rd 1, rs1 0, imm 5), mem_ready=1 → next cycle mem_we=1, addr 0x0, wdata 0x00500093.
- Stream back-to-back with mem_ready=1:
  - lw x2,8(x1) → 0x0080A103 @0x4.
  - sw x2,4(x1) → 0x0020A223 @0x8.
  - add x3,x1,x2 → 0x002081B3 @0xC.
  - sub x3,x1,x2 → 0x402081B3 @0x10.
- beq x1,x2,−4 → 0xFE208EE3.
- jal x1,8 → 0x008000EF.
- Errors:
  - beq with imm 3 → err=1, code 3, no write.
  - Then addi imm 2048 → err_code stays 3.
  - err_clr → err=0, code 0.
- Backpressure: hold mem_ready=0 and push 3 legal requests with DEPTH=2 → in_ready=0 after 2. mem_addr/mem_wdata stay stable. Release → 2 writes at consecutive addresses, then the third request is accepted.
- Edge cases:
  - addr_load to 0xFFFFFFFC coinciding with a completing write → that write goes to the old address. The next write goes to 0xFFFFFFFC, then the one after wraps to 0x0.
  - Assert reset mid-stream → mem_we=0, mem_addr=BASE_ADDR.
